instr_mem_loader: RTL and testbench

- Encoder/writer side of the instruction path.
- Accepts decoded instruction fields from a testbench or host over a valid/ready handshake.
- Packs them into 16-bit instruction words in the format `mainController` decodes, and writes them sequentially into instruction memory.
- When loading ends, appends a halt word and releases the CPU via `cpu_start`. Sits between the host and the instruction memory, ahead of the single-cycle datapath.

---
 rtl/instr_mem_loader_pkg.sv | 37 +++
 rtl/instr_mem_loader_encoder.sv | 44 ++++
 rtl/instr_mem_loader.sv | 165 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : instr_mem_loader_pkg
// Purpose : Opcodes, instruction field positions and loader FSM states.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package instr_mem_loader_pkg;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_RTYPE = 4'b1000;

  localparam int OP_LSB   = 12;
  localparam int RS_LSB   = 9;
  localparam int RT_LSB   = 6;
  localparam int RD_LSB   = 3;
  localparam int FUNC_LSB = 0;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HALT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic legal_op(input logic [3:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_JUMP, OP_BEQ, OP_RTYPE: legal_op = 1'b1;
      default:                                      legal_op = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_loader_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : instr_encoder
// Purpose : Packs decoded fields into a 16-bit instruction word.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module instr_encoder
  import instr_mem_loader_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [2:0]  rs,
  input  logic [2:0]  rt,
  input  logic [2:0]  rd,
  input  logic [2:0]  func,
  input  logic [11:0] imm,
  output logic [15:0] word,
  output logic        legal
);

  always_comb begin
    word = '0;
    word[OP_LSB +: 4] = op;
    case (op)
      OP_RTYPE: begin
        word[RS_LSB +: 3]   = rs;
        word[RT_LSB +: 3]   = rt;
        word[RD_LSB +: 3]   = rd;
        word[FUNC_LSB +: 3] = func;
      end
      OP_JUMP: begin
        word[IMM_LSB +: 12] = imm;
      end
      default: begin
        // I-type layout; only the low six immediate bits fit
        word[RS_LSB +: 3]  = rs;
        word[RT_LSB +: 3]  = rt;
        word[IMM_LSB +: 6] = imm[5:0];
      end
    endcase
    legal = legal_op(op);
  end

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : instr_mem_loader
// Purpose : Writes host-supplied instructions to memory, appends a halt word
//           and releases the CPU.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [3:0]    in_op,
  input  logic [2:0]    in_rs,
  input  logic [2:0]    in_rt,
  input  logic [2:0]    in_rd,
  input  logic [2:0]    in_func,
  input  logic [11:0]   in_imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic [AW:0]   word_count,
  output logic          cpu_start,
  output logic          err_illegal,
  output logic          err_full
);

  localparam logic [1:0]  S_IDLE    = 2'(ST_IDLE);
  localparam logic [1:0]  S_LOAD    = 2'(ST_LOAD);
  localparam logic [1:0]  S_HALT    = 2'(ST_HALT);
  localparam logic [1:0]  S_DONE    = 2'(ST_DONE);
  localparam logic [AW:0] C_DEPTH   = DEPTH[AW:0];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic          cpu_start_q, cpu_start_d;
  logic          err_illegal_q, err_illegal_d;
  logic          err_full_q, err_full_d;

  logic [15:0]   enc_word;
  logic          enc_legal;
  logic          accept;
  logic [AW:0]   count_inc;
  logic          fills_mem;
  logic [11:0]   addr_ext;

  instr_encoder u_encoder (
    .op    (in_op),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .func  (in_func),
    .imm   (in_imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  always_comb begin
    in_ready  = (state_q == S_LOAD) && (count_q < C_DEPTH);
    accept    = in_valid && in_ready;
    count_inc = count_q + (AW+1)'(1);
    fills_mem = enc_legal && (count_inc == C_DEPTH);
    addr_ext  = 12'(addr_q);
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    count_d       = count_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_start_d   = 1'b0;
    err_illegal_d = err_illegal_q;
    err_full_d    = err_full_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          addr_d        = '0;
          count_d       = '0;
          err_illegal_d = 1'b0;
          err_full_d    = 1'b0;
          state_d       = S_LOAD;
        end else if (state_q == S_DONE) begin
          cpu_start_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (enc_legal) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = enc_word;
            addr_d      = addr_q + AW'(1);
            count_d     = count_inc;
          end else begin
            err_illegal_d = 1'b1;
          end
          // A dropped last beat still closes the program with a halt word
          if (in_last) begin
            state_d = fills_mem ? S_DONE : S_HALT;
          end else if (fills_mem) begin
            err_full_d = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_HALT: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = {OP_JUMP, addr_ext};
        addr_d      = addr_q + AW'(1);
        count_d     = count_inc;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      count_q       <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_start_q   <= 1'b0;
      err_illegal_q <= 1'b0;
      err_full_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_start_q   <= cpu_start_d;
      err_illegal_q <= err_illegal_d;
      err_full_q    <= err_full_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign word_count  = count_q;
  assign cpu_start   = cpu_start_q;
  assign err_illegal = err_illegal_q;
  assign err_full    = err_full_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_instr_mem_loader
// Purpose : Scoreboard bench for instr_mem_loader with a program-level model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

  localparam int TB_DEPTH = 4;
  localparam int TB_AW    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [3:0]        in_op = '0;
  logic [2:0]        in_rs = '0, in_rt = '0, in_rd = '0, in_func = '0;
  logic [11:0]       in_imm = '0;
  logic              mem_we;
  logic [TB_AW-1:0]  mem_addr;
  logic [15:0]       mem_wdata;
  logic [TB_AW:0]    word_count;
  logic              cpu_start;
  logic              err_illegal;
  logic              err_full;

  instr_mem_loader #(.DEPTH(TB_DEPTH)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_func(in_func), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .cpu_start(cpu_start),
    .err_illegal(err_illegal), .err_full(err_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rs, rt, rd, fn;
    logic [11:0] imm;
    logic        last;
  } beat_t;

  typedef struct {
    int addr;
    int data;
    int cnt;
  } wr_t;

  beat_t prog[$];
  wr_t   exp_q[$];
  int    wr_cyc[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc = 0;
  int    last_we_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic bit model_legal(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd4) || (op == 4'd8);
  endfunction

  // Instruction word written out as weighted field sums
  function automatic int model_word(input beat_t b);
    int op;
    op = int'(b.op);
    if (op == 8) return op*4096 + int'(b.rs)*512 + int'(b.rt)*64 + int'(b.rd)*8 + int'(b.fn);
    if (op == 2) return op*4096 + int'(b.imm);
    return op*4096 + int'(b.rs)*512 + int'(b.rt)*64 + (int'(b.imm) % 64);
  endfunction

  // Scoreboard monitor: every write must match the head of the queue
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", int'(mem_addr), e.addr);
        check("wr_data", int'(mem_wdata), e.data);
        check("wr_count", int'(word_count), e.cnt);
      end
      last_we_cyc = cyc;
      wr_cyc.push_back(cyc);
    end
  end

  task automatic add_beat(input int op, input int rs, input int rt, input int rd,
                          input int fn, input int imm, input bit last);
    beat_t b;
    b.op = op[3:0]; b.rs = rs[2:0]; b.rt = rt[2:0]; b.rd = rd[2:0];
    b.fn = fn[2:0]; b.imm = imm[11:0]; b.last = last;
    prog.push_back(b);
  endtask

  function automatic int rand_op(input bit allow_illegal);
    int legal_ops[5] = '{0, 1, 2, 4, 8};
    int op;
    if (allow_illegal && ($urandom_range(0, 9) < 3)) begin
      do op = $urandom_range(0, 15); while (model_legal(op[3:0]));
      return op;
    end
    return legal_ops[$urandom_range(0, 4)];
  endfunction

  task automatic rand_program();
    int len;
    bit with_last;
    prog.delete();
    len = $urandom_range(1, 6);
    with_last = ($urandom_range(0, 9) < 7);
    for (int i = 0; i < len; i++)
      add_beat(rand_op(1'b1), $urandom, $urandom, $urandom, $urandom, $urandom,
               with_last && (i == len - 1));
    if (!with_last)
      for (int i = 0; i < TB_DEPTH; i++)
        add_beat(rand_op(1'b0), $urandom, $urandom, $urandom, $urandom, $urandom, 1'b0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    check("restart_cpu_start", int'(cpu_start), 0);
    check("restart_count", int'(word_count), 0);
    check("restart_errors", int'({err_illegal, err_full}), 0);
  endtask

  task automatic run_session(input int gap_max, input bit poke);
    int  a = 0;
    int  n = 0;
    int  t;
    bit  ended = 0, ei = 0, ef = 0;
    foreach (prog[i]) begin
      if (!ended) begin
        n++;
        if (model_legal(prog[i].op)) begin
          exp_q.push_back('{a, model_word(prog[i]), a + 1});
          a++;
        end else begin
          ei = 1;
        end
        if (prog[i].last) begin
          ended = 1;
          if (a < TB_DEPTH) begin
            exp_q.push_back('{a, 32'h2000 + a, a + 1});
            a++;
          end
        end else if (a == TB_DEPTH) begin
          ended = 1;
          ef = 1;
        end
      end
    end
    wr_cyc.delete();
    pulse_start();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_op = prog[i].op; in_rs = prog[i].rs; in_rt = prog[i].rt; in_rd = prog[i].rd;
      in_func = prog[i].fn; in_imm = prog[i].imm; in_last = prog[i].last;
      in_valid = 1'b1;
      load_start = poke && ($urandom_range(0, 1) == 1);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 20) begin @(negedge clk); t++; end
      if (!in_ready) check("beat_ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last = 1'b0;
      load_start = 1'b0;
    end
    t = 0;
    while (!cpu_start && t < 30) begin @(negedge clk); t++; end
    check("cpu_start_rise", int'(cpu_start), 1);
    check("cpu_start_latency", cyc - last_we_cyc, 1);
    repeat (2) @(negedge clk);
    check("pending_writes", exp_q.size(), 0);
    check("final_count", int'(word_count), a);
    check("err_illegal", int'(err_illegal), int'(ei));
    check("err_full", int'(err_full), int'(ef));
    check("ready_low_done", int'(in_ready), 0);
    check("cpu_start_held", int'(cpu_start), 1);
  endtask

  initial begin
    #1;
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_outputs", int'({mem_addr, mem_wdata, word_count}), 0);
    check("rst_flags", int'({cpu_start, err_illegal, err_full, in_ready}), 0);
    #12 rst = 1'b1;

    // R-type followed by halt
    prog.delete();
    add_beat(8, 1, 2, 3, 4, 0, 1'b1);
    run_session(0, 1'b0);

    // Load with truncated immediate, then jump
    prog.delete();
    add_beat(0, 2, 5, 0, 0, 12'hFC5, 1'b0);
    add_beat(2, 0, 0, 0, 0, 12'hABC, 1'b1);
    run_session(1, 1'b0);

    // Illegal opcode dropped between two legal beats
    prog.delete();
    add_beat(1, 3, 4, 0, 0, 12'h011, 1'b0);
    add_beat(15, 7, 7, 7, 7, 12'hFFF, 1'b0);
    add_beat(4, 6, 1, 0, 0, 12'h03F, 1'b1);
    run_session(0, 1'b0);

    // Overflow without last: four writes, no halt
    prog.delete();
    for (int i = 0; i < 5; i++) add_beat(8, i, i + 1, i + 2, i + 3, 0, 1'b0);
    run_session(0, 1'b0);

    // Back-to-back burst on consecutive cycles
    prog.delete();
    add_beat(8, 7, 6, 5, 4, 0, 1'b0);
    add_beat(0, 1, 1, 0, 0, 12'h02A, 1'b0);
    add_beat(2, 0, 0, 0, 0, 12'h123, 1'b1);
    run_session(0, 1'b0);
    check("burst_gap_1", wr_cyc[1] - wr_cyc[0], 1);
    check("burst_gap_2", wr_cyc[2] - wr_cyc[1], 1);

    // Exact fill with last on the final slot
    prog.delete();
    for (int i = 0; i < 4; i++) add_beat(4, i, 7 - i, 0, 0, i * 9, i == 3);
    run_session(0, 1'b1);

    // Reset in the middle of a stream
    prog.delete();
    exp_q.delete();
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    add_beat(8, 5, 4, 3, 2, 0, 1'b0);
    add_beat(1, 2, 3, 0, 0, 12'h00F, 1'b0);
    exp_q.push_back('{0, model_word(prog[0]), 1});
    exp_q.push_back('{1, model_word(prog[1]), 2});
    in_op = prog[0].op; in_rs = prog[0].rs; in_rt = prog[0].rt; in_rd = prog[0].rd;
    in_func = prog[0].fn; in_imm = prog[0].imm; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_op = prog[1].op; in_rs = prog[1].rs; in_rt = prog[1].rt; in_rd = prog[1].rd;
    in_func = prog[1].fn; in_imm = prog[1].imm;
    @(posedge clk); #1;
    in_op = 4'd8;
    @(negedge clk); #2 rst = 1'b0;
    #1;
    check("midrst_mem_we", int'(mem_we), 0);
    check("midrst_outputs", int'({mem_addr, mem_wdata, word_count}), 0);
    check("midrst_flags", int'({cpu_start, err_illegal, err_full, in_ready}), 0);
    check("midrst_writes_seen", exp_q.size(), 0);
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    check("idle_after_rst_ready", int'(in_ready), 0);

    for (int s = 0; s < 40; s++) begin
      rand_program();
      run_session($urandom_range(0, 2), $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
